uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares one UART transmit line among `NUM_REQ` byte sources. It selects a requester by round-robin arbitration, latches that requester's byte and acknowledges it, then serializes the byte as a standard 8N1-style frame. The frame is one start bit, `DATA_WIDTH` data bits LSB first, and one stop bit. It is the transmit-side counterpart to `uart_rx` and runs on the same clock and reset.

## Interface
- `DATA_WIDTH`, default 8: bits per frame payload.
- `NUM_REQ`, default 4: number of requesters, ≥2.
- `CLKS_PER_BIT`, default 16: clock cycles per serial bit, ≥2.

- `clk`  in  1: single clock, all state on rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `req`  in  NUM_REQ: per-requester transmit request, level.
- `data_in`  in  NUM_REQ*DATA_WIDTH: flattened bytes; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `ack`  out  NUM_REQ: one-hot, one-cycle pulse when requester's byte is latched.
- `grant_id`  out  $clog2(NUM_REQ): index of the requester currently or last served.
- `busy`  out  1: high while a frame is on the line.
- `dout`  out  1: serial output, idle high.

## Operation
- Registered FSM with states IDLE, START, DATA and STOP.
  - Internal registers:
    - shift register, DATA_WIDTH bits.
    - baud counter, $clog2(CLKS_PER_BIT) bits, counts 0..CLKS_PER_BIT-1.
    - bit counter, counts 0..DATA_WIDTH-1.
    - `last` pointer, $clog2(NUM_REQ) bits.
- IDLE:
  - `dout`=1 and `busy`=0.
  - If any `req` bit is high, select the first set bit searching from `last`+1 upward, wrapping modulo NUM_REQ.
  - On that edge:
    - shift ← selected byte.
    - `ack[g]` ← 1.
    - `grant_id` ← g and `last` ← g.
    - `busy` ← 1 and `dout` ← 0.
    - baud counter ← 0 and state ← START.
- START:
  - `dout`=0 for CLKS_PER_BIT cycles.
  - When the baud counter reaches CLKS_PER_BIT-1: counter ← 0, `dout` ← shift[0], state ← DATA.
- DATA:
  - Each bit is held for CLKS_PER_BIT cycles.
  - At the end of each bit:
    - shift right by one.
    - `dout` ← next bit.
    - bit counter increments.
  - After bit DATA_WIDTH-1 completes: `dout` ← 1, state ← STOP.
- STOP:
  - `dout`=1 for CLKS_PER_BIT cycles.
  - Then `busy` ← 0 and state ← IDLE.
- `ack` is a single-cycle pulse. All `ack` bits are 0 in every other cycle.
- Requester protocol:
  - Hold `req` and `data_in` stable until `ack`.
  - `req` still high on the cycle after `ack` is a new request.
- `req` changes outside IDLE are ignored. A request dropped before the FSM returns to IDLE is never served.

## Timing
- Reset values: `dout`=1, `busy`=0, `ack`=0, `grant_id`=0, `last`=NUM_REQ-1 (requester 0 has first priority), state=IDLE, counters and shift register 0.
- Reset assertion mid-frame:
  - Outputs take their reset values immediately, asynchronously.
  - The frame is truncated and no partial data is retained.
- Latency: start bit appears on `dout` the cycle after the IDLE edge that samples `req`. `ack` is asserted in that same cycle.
- Frame length: exactly (DATA_WIDTH+2)*CLKS_PER_BIT cycles with `busy`=1.
- Back-to-back requests: exactly one IDLE cycle (`dout`=1, `busy`=0) separates the end of a stop bit from the next start bit. The effective stop width is CLKS_PER_BIT+1.
- Pointer wrap: after granting NUM_REQ-1, the search begins at 0.

## Test plan
1. Single transmission (NUM_REQ=4, CLKS_PER_BIT=4, DATA_WIDTH=8). Stimulus: `req`=0001, byte0=0xA5.
   - `ack`=0001 for 1 cycle and `grant_id`=0.
   - `dout`: 0 ×4 cycles, then 1,0,1,0,0,1,0,1 each ×4, then 1 ×4.
   - `busy` high for exactly 40 cycles.
2. Fairness: all four `req` held high continuously with distinct bytes 0x11/0x22/0x33/0x44.
   - Grants 0,1,2,3,0 in order.
   - Frames carry the matching byte.
   - One idle cycle between frames.
3. Rotation: grant requester 2, then assert `req`=0110 during that frame.
   - Next grant is 1, because the search from 3 wraps past 0 to 1; requester 2 waits until after 1.
4. Reset mid-DATA: assert `reset` low during the 3rd data bit.
   - `dout`=1, `busy`=0, `ack`=0 immediately.
   - After release with `req`=1111, first grant is 0.
5. Dropped request: `req`=0100 pulsed for 3 cycles while `busy`=1 and deasserted before IDLE.
   - No `ack[2]`.
   - Line stays idle high after the current frame.
6. Held request: `req[3]` held high for 100 cycles with byte 0xFF.
   - Two full frames, each with its own single-cycle `ack[3]`.
   - Frames separated by exactly one idle cycle.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbitrated UART transmitter: picks one of NUM_REQ byte sources,
// acknowledges it, then sends a start bit, DATA_WIDTH data bits LSB first and a stop bit.
module uart_tx_arbiter #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned CLKS_PER_BIT = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] data_in,
  output logic [NUM_REQ-1:0]            ack,
  output logic [$clog2(NUM_REQ)-1:0]    grant_id,
  output logic                          busy,
  output logic                          dout
);

  localparam int unsigned IdxW  = $clog2(NUM_REQ);
  localparam int unsigned BaudW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW  = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

  state_e                  state_q, state_d;
  logic [DATA_WIDTH-1:0]   shift_q, shift_d;
  logic [BaudW-1:0]        baud_q, baud_d;
  logic [BitW-1:0]         bit_q, bit_d;
  logic [IdxW-1:0]         last_q, last_d;
  logic [IdxW-1:0]         grant_q, grant_d;
  logic [NUM_REQ-1:0]      ack_q, ack_d;
  logic                    busy_q, busy_d;
  logic                    dout_q, dout_d;

  logic                    sel_found;
  logic [IdxW-1:0]         sel_idx;
  logic                    baud_last;
  logic                    bit_last;

  assign baud_last = (baud_q == BaudW'(CLKS_PER_BIT - 1));
  assign bit_last  = (bit_q == BitW'(DATA_WIDTH - 1));

  // Round-robin search: first set req bit starting just after the last grant, wrapping.
  always_comb begin
    int unsigned cand;
    cand      = 0;
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int unsigned i = 1; i <= NUM_REQ; i++) begin
      cand = (32'(last_q) + i) % NUM_REQ;
      if (!sel_found && req[IdxW'(cand)]) begin
        sel_found = 1'b1;
        sel_idx   = IdxW'(cand);
      end
    end
  end

  // Next-state and registered-output logic for the frame FSM.
  always_comb begin
    state_d = state_q;
    shift_d = shift_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    last_d  = last_q;
    grant_d = grant_q;
    ack_d   = '0;
    busy_d  = busy_q;
    dout_d  = dout_q;

    unique case (state_q)
      StIdle: begin
        if (sel_found) begin
          shift_d = data_in[sel_idx*DATA_WIDTH +: DATA_WIDTH];
          ack_d   = NUM_REQ'(1) << sel_idx;
          grant_d = sel_idx;
          last_d  = sel_idx;
          busy_d  = 1'b1;
          dout_d  = 1'b0;
          baud_d  = '0;
          bit_d   = '0;
          state_d = StStart;
        end
      end
      StStart: begin
        if (baud_last) begin
          baud_d  = '0;
          bit_d   = '0;
          dout_d  = shift_q[0];
          state_d = StData;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StData: begin
        if (baud_last) begin
          baud_d = '0;
          if (bit_last) begin
            dout_d  = 1'b1;
            state_d = StStop;
          end else begin
            // Present the next bit from the shifted value so DATA_WIDTH=1 stays in range.
            shift_d = shift_q >> 1;
            dout_d  = shift_d[0];
            bit_d   = bit_q + 1'b1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      StStop: begin
        if (baud_last) begin
          baud_d  = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State register; reset drops any frame in flight and returns the line to idle high.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      shift_q <= '0;
      baud_q  <= '0;
      bit_q   <= '0;
      last_q  <= IdxW'(NUM_REQ - 1);
      grant_q <= '0;
      ack_q   <= '0;
      busy_q  <= 1'b0;
      dout_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      shift_q <= shift_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      ack_q   <= ack_d;
      busy_q  <= busy_d;
      dout_q  <= dout_d;
    end
  end

  assign ack      = ack_q;
  assign grant_id = grant_q;
  assign busy     = busy_q;
  assign dout     = dout_q;

endmodule
